// File: rtl/rv32_branch_predictor.sv
// Bimodal BHT plus direct-mapped BTB next-PC predictor for the fetch stage.
// Both tables are cleared by an init walk after reset; predictions are registered.
module rv32_branch_predictor #(
    parameter int unsigned BHT_ENTRIES  = 64,
    parameter int unsigned BTB_ENTRIES  = 16,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic [31:0] lookup_pc_in,
    output logic        ready_out,
    output logic        predicted_taken_out,
    output logic [31:0] predicted_pc_out,
    input  logic        update_valid_in,
    input  logic [31:0] update_pc_in,
    input  logic        update_taken_in,
    input  logic [31:0] update_target_in
);

    localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - BTB_W;
    localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                  state_q, state_d;
    logic [BHT_W-1:0]        init_idx_q, init_idx_d;
    logic                    taken_q, taken_d;
    logic [31:0]             pc_q, pc_d;

    logic [COUNTER_BITS-1:0] bht_q [BHT_ENTRIES];
    logic [COUNTER_BITS-1:0] bht_d [BHT_ENTRIES];
    logic                    btb_valid_q [BTB_ENTRIES];
    logic                    btb_valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0]        btb_tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]        btb_tag_d [BTB_ENTRIES];
    logic [31:1]             btb_tgt_q [BTB_ENTRIES];
    logic [31:1]             btb_tgt_d [BTB_ENTRIES];

    logic [BHT_W-1:0]        l_bht_idx, u_bht_idx;
    logic [BTB_W-1:0]        l_btb_idx, u_btb_idx;
    logic [TAG_W-1:0]        l_tag, u_tag;
    logic                    l_hit, l_taken;
    logic [COUNTER_BITS-1:0] u_ctr;

    assign l_bht_idx = lookup_pc_in[BHT_W+1:2];
    assign l_btb_idx = lookup_pc_in[BTB_W+1:2];
    assign l_tag     = lookup_pc_in[31:BTB_W+2];
    assign u_bht_idx = update_pc_in[BHT_W+1:2];
    assign u_btb_idx = update_pc_in[BTB_W+1:2];
    assign u_tag     = update_pc_in[31:BTB_W+2];

    // Lookup reads the _q tables, so a same-cycle update is seen only by later lookups.
    assign l_hit   = btb_valid_q[l_btb_idx] && (btb_tag_q[l_btb_idx] == l_tag);
    assign l_taken = (state_q == READY) && l_hit && bht_q[l_bht_idx][COUNTER_BITS-1];

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        taken_d     = taken_q;
        pc_d        = pc_q;
        bht_d       = bht_q;
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        u_ctr       = bht_q[u_bht_idx];

        if (!stall_in) begin
            taken_d = l_taken;
            pc_d    = l_taken ? {btb_tgt_q[l_btb_idx], 1'b0} : lookup_pc_in + 32'd4;
        end

        case (state_q)
            INIT: begin
                bht_d[init_idx_q] = CTR_INIT;
                if (32'(init_idx_q) < BTB_ENTRIES) begin
                    btb_valid_d[init_idx_q[BTB_W-1:0]] = 1'b0;
                end
                if (init_idx_q == BHT_W'(BHT_ENTRIES - 1)) begin
                    state_d = READY;
                end
                init_idx_d = init_idx_q + BHT_W'(1);
            end
            READY: begin
                if (update_valid_in) begin
                    if (update_taken_in) begin
                        if (u_ctr != '1) u_ctr = u_ctr + COUNTER_BITS'(1);
                        btb_valid_d[u_btb_idx] = 1'b1;
                        btb_tag_d[u_btb_idx]   = u_tag;
                        btb_tgt_d[u_btb_idx]   = update_target_in[31:1];
                    end else begin
                        if (u_ctr != '0) u_ctr = u_ctr - COUNTER_BITS'(1);
                    end
                    bht_d[u_bht_idx] = u_ctr;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Table contents are not reset directly; the INIT walk rewrites every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            taken_q    <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            taken_q     <= taken_d;
            pc_q        <= pc_d;
            bht_q       <= bht_d;
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
        end
    end

    assign ready_out           = (state_q == READY);
    assign predicted_taken_out = taken_q;
    assign predicted_pc_out    = pc_q;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed bench for rv32_branch_predictor with default parameters.
module tb_rv32_branch_predictor;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic [31:0] lookup_pc_in;
    logic        ready_out;
    logic        predicted_taken_out;
    logic [31:0] predicted_pc_out;
    logic        update_valid_in;
    logic [31:0] update_pc_in;
    logic        update_taken_in;
    logic [31:0] update_target_in;

    int total;
    int bad;

    rv32_branch_predictor #(
        .BHT_ENTRIES (64),
        .BTB_ENTRIES (16),
        .COUNTER_BITS(2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_in           (stall_in),
        .lookup_pc_in       (lookup_pc_in),
        .ready_out          (ready_out),
        .predicted_taken_out(predicted_taken_out),
        .predicted_pc_out   (predicted_pc_out),
        .update_valid_in    (update_valid_in),
        .update_pc_in       (update_pc_in),
        .update_taken_in    (update_taken_in),
        .update_target_in   (update_target_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                          input logic [31:0] exp_pc);
        lookup_pc_in = pc;
        tick();
        check({tag, "_taken"}, {31'd0, predicted_taken_out}, {31'd0, exp_taken});
        check({tag, "_pc"}, predicted_pc_out, exp_pc);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_valid_in  = 1'b1;
        update_pc_in     = pc;
        update_taken_in  = taken;
        update_target_in = tgt;
        tick();
        update_valid_in  = 1'b0;
    endtask

    // Walks the whole init window: ready low for 64 samples, lookups fall through,
    // and a taken update held the whole time must be ignored.
    task automatic init_window(input string tag);
        update_valid_in  = 1'b1;
        update_pc_in     = 32'h0000_0100;
        update_taken_in  = 1'b1;
        update_target_in = 32'h0000_0040;
        for (int i = 0; i < 64; i++) begin
            check({tag, "_ready_low"}, {31'd0, ready_out}, 32'd0);
            lookup_pc_in = 32'h0000_1000 + 32'(i) * 32'd4;
            tick();
            check({tag, "_init_taken"}, {31'd0, predicted_taken_out}, 32'd0);
            check({tag, "_init_pc"}, predicted_pc_out, 32'h0000_1004 + 32'(i) * 32'd4);
        end
        update_valid_in = 1'b0;
        check({tag, "_ready_high"}, {31'd0, ready_out}, 32'd1);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        stall_in         = 1'b0;
        lookup_pc_in     = '0;
        update_valid_in  = 1'b0;
        update_pc_in     = '0;
        update_taken_in  = 1'b0;
        update_target_in = '0;

        tick();
        tick();
        check("rst_ready", {31'd0, ready_out}, 32'd0);
        check("rst_taken", {31'd0, predicted_taken_out}, 32'd0);
        check("rst_pc", predicted_pc_out, 32'd0);
        reset = 1'b0;
        init_window("init1");

        lookup("fresh_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
        train(32'h0000_0100, 1'b1, 32'h0000_0040);
        lookup("t1_100", 32'h0000_0100, 1'b1, 32'h0000_0040);
        train(32'h0000_0100, 1'b0, 32'h0);
        train(32'h0000_0100, 1'b0, 32'h0);
        lookup("nt2_100", 32'h0000_0100, 1'b0, 32'h0000_0104);

        // 0x200 shares BHT[0] (now 00); five taken updates saturate at 11.
        for (int i = 0; i < 5; i++) train(32'h0000_0200, 1'b1, 32'h0000_0280);
        lookup("sat_t5", 32'h0000_0200, 1'b1, 32'h0000_0280);
        train(32'h0000_0200, 1'b0, 32'h0);
        lookup("sat_nt1", 32'h0000_0200, 1'b1, 32'h0000_0280);
        train(32'h0000_0200, 1'b0, 32'h0);
        lookup("sat_nt2", 32'h0000_0200, 1'b0, 32'h0000_0204);
        train(32'h0000_0200, 1'b0, 32'h0);
        lookup("sat_nt3", 32'h0000_0200, 1'b0, 32'h0000_0204);

        train(32'h0000_1000, 1'b1, 32'h0000_2000);
        train(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup("alias_pre", 32'h0000_1000, 1'b1, 32'h0000_2000);
        train(32'h0000_1040, 1'b1, 32'h0000_3000);
        lookup("alias_miss", 32'h0000_1000, 1'b0, 32'h0000_1004);
        lookup("alias_hit", 32'h0000_1040, 1'b1, 32'h0000_3000);

        update_valid_in  = 1'b1;
        update_pc_in     = 32'h0000_0080;
        update_taken_in  = 1'b1;
        update_target_in = 32'h0000_0500;
        lookup("hazard_old", 32'h0000_0080, 1'b0, 32'h0000_0084);
        update_valid_in = 1'b0;
        lookup("hazard_new", 32'h0000_0080, 1'b1, 32'h0000_0500);

        stall_in = 1'b1;
        lookup("stall1", 32'h0000_1040, 1'b1, 32'h0000_0500);
        update_valid_in  = 1'b1;
        update_pc_in     = 32'h0000_0100;
        update_taken_in  = 1'b1;
        update_target_in = 32'h0000_0040;
        lookup("stall2", 32'h0000_0200, 1'b1, 32'h0000_0500);
        update_valid_in = 1'b0;
        lookup("stall3", 32'h0000_0100, 1'b1, 32'h0000_0500);
        stall_in = 1'b0;
        lookup("stall_upd", 32'h0000_0100, 1'b1, 32'h0000_0040);

        update_valid_in  = 1'b1;
        update_pc_in     = 32'h0000_0300;
        update_taken_in  = 1'b1;
        update_target_in = 32'h0000_0700;
        reset            = 1'b1;
        tick();
        check("rrdy_ready", {31'd0, ready_out}, 32'd0);
        check("rrdy_taken", {31'd0, predicted_taken_out}, 32'd0);
        check("rrdy_pc", predicted_pc_out, 32'd0);
        tick();
        reset           = 1'b0;
        update_valid_in = 1'b0;

        for (int i = 0; i < 30; i++) tick();
        check("mid_ready", {31'd0, ready_out}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        init_window("init2");

        lookup("clr_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
        lookup("clr_1040", 32'h0000_1040, 1'b0, 32'h0000_1044);
        lookup("clr_80", 32'h0000_0080, 1'b0, 32'h0000_0084);
        lookup("clr_300", 32'h0000_0300, 1'b0, 32'h0000_0304);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
